// File: rtl/event_encoder_4to2_if.sv
// Request/handshake bundle for the 4-to-2 event encoder.
// The slave side is the encoder; the master side is the event source plus consumer.
interface event_encoder_4to2_if;
   logic [3:0] req;
   logic       ready;
   logic [1:0] code;
   logic       valid;
   logic [3:0] pending;
   logic       overflow;

   modport master (
      output req,
      output ready,
      input  code,
      input  valid,
      input  pending,
      input  overflow
   );

   modport slave (
      input  req,
      input  ready,
      output code,
      output valid,
      output pending,
      output overflow
   );
endinterface

// File: rtl/event_encoder_4to2.sv
// Captures single-cycle events on four request lines into sticky pending bits and
// emits them one at a time as 2-bit indices over a valid/ready handshake.
module event_encoder_4to2 #(
   parameter bit ROUND_ROBIN = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   event_encoder_4to2_if.slave  bus
);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t     state_p1, state_nxt;
   logic [3:0] pending_p1, pending_nxt;
   logic [1:0] code_p1, code_nxt;
   logic [1:0] last_p1, last_nxt;
   logic       ovf_p1, ovf_nxt;
   logic [1:0] winner;
   logic       load;
   logic [3:0] clr;

   function automatic logic [1:0] pick_fixed(input logic [3:0] p);
      logic [1:0] idx;
      if (p[3])      idx = 2'd3;
      else if (p[2]) idx = 2'd2;
      else if (p[1]) idx = 2'd1;
      else           idx = 2'd0;
      return idx;
   endfunction

   // Search starts one past the last emitted index and wraps modulo 4.
   function automatic logic [1:0] pick_rr(input logic [3:0] p, input logic [1:0] last);
      logic [1:0] idx;
      logic [1:0] sel;
      logic       found;
      sel   = last;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = last + k[1:0];
         if (!found && p[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   always_comb begin
      state_nxt   = state_p1;
      code_nxt    = code_p1;
      last_nxt    = last_p1;
      load        = 1'b0;
      clr         = 4'b0000;
      winner      = ROUND_ROBIN ? pick_rr(pending_p1, last_p1) : pick_fixed(pending_p1);

      unique case (state_p1)
         IDLE: begin
            if (|pending_p1) begin
               load      = 1'b1;
               state_nxt = PRESENT;
            end
         end
         PRESENT: begin
            // Without ready the presented code is frozen, even if a higher index arrives.
            if (bus.ready) begin
               if (|pending_p1) load      = 1'b1;
               else             state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (load) begin
         clr      = 4'b0001 << winner;
         code_nxt = winner;
         last_nxt = winner;
      end

      // A req landing on the bit being cleared re-arms it as a fresh event.
      pending_nxt = (pending_p1 & ~clr) | bus.req;
      ovf_nxt     = |(bus.req & pending_p1 & ~clr);
   end

   // ---- stage p1: registered state and outputs ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state_p1   <= IDLE;
         pending_p1 <= 4'b0000;
         code_p1    <= 2'd0;
         last_p1    <= 2'd3;
         ovf_p1     <= 1'b0;
      end else begin
         state_p1   <= state_nxt;
         pending_p1 <= pending_nxt;
         code_p1    <= code_nxt;
         last_p1    <= last_nxt;
         ovf_p1     <= ovf_nxt;
      end
   end

   assign bus.code     = code_p1;
   assign bus.valid    = (state_p1 == PRESENT);
   assign bus.pending  = pending_p1;
   assign bus.overflow = ovf_p1;

endmodule

// File: tb/tb_event_encoder_4to2.sv
// Scoreboard bench: fixed-priority and round-robin encoders driven in lockstep,
// expected codes queued at stimulus time and popped on each handshake.
module tb_event_encoder_4to2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   event_encoder_4to2_if bus_fp ();
   event_encoder_4to2_if bus_rr ();

   event_encoder_4to2 #(.ROUND_ROBIN(1'b0)) dut_fp (
      .clk (clk),
      .rst (rst),
      .bus (bus_fp)
   );

   event_encoder_4to2 #(.ROUND_ROBIN(1'b1)) dut_rr (
      .clk (clk),
      .rst (rst),
      .bus (bus_rr)
   );

   int n_chk  = 0;
   int n_fail = 0;
   logic [1:0] q_fp[$];
   logic [1:0] q_rr[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Handshake monitor: valid && ready seen here completes on the next rising edge.
   always @(negedge clk) begin
      if (!rst && bus_fp.valid === 1'b1 && bus_fp.ready === 1'b1) begin
         chk("fp_sb_has_entry", 32'(q_fp.size() != 0), 32'd1);
         if (q_fp.size() != 0) chk("fp_code", 32'(bus_fp.code), 32'(q_fp.pop_front()));
      end
      if (!rst && bus_rr.valid === 1'b1 && bus_rr.ready === 1'b1) begin
         chk("rr_sb_has_entry", 32'(q_rr.size() != 0), 32'd1);
         if (q_rr.size() != 0) chk("rr_code", 32'(bus_rr.code), 32'(q_rr.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] r, input logic rdy);
      bus_fp.req   = r;
      bus_fp.ready = rdy;
      bus_rr.req   = r;
      bus_rr.ready = rdy;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(4'b0000, 1'b0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic both_state(input string tag, input logic vld, input logic [1:0] cd,
                             input logic [3:0] pnd);
      chk({tag, "_fp_valid"},   32'(bus_fp.valid),   32'(vld));
      chk({tag, "_rr_valid"},   32'(bus_rr.valid),   32'(vld));
      chk({tag, "_fp_code"},    32'(bus_fp.code),    32'(cd));
      chk({tag, "_rr_code"},    32'(bus_rr.code),    32'(cd));
      chk({tag, "_fp_pending"}, 32'(bus_fp.pending), 32'(pnd));
      chk({tag, "_rr_pending"}, 32'(bus_rr.pending), 32'(pnd));
   endtask

   task automatic both_ovf(input string tag, input logic ovf);
      chk({tag, "_fp_overflow"}, 32'(bus_fp.overflow), 32'(ovf));
      chk({tag, "_rr_overflow"}, 32'(bus_rr.overflow), 32'(ovf));
   endtask

   // Runs until both DUTs are idle and both scoreboards are empty, bounded.
   task automatic drain(input string tag, input int exp_cyc);
      int cyc;
      cyc = 0;
      while ((bus_fp.valid !== 1'b0 || bus_rr.valid !== 1'b0 ||
              q_fp.size() != 0 || q_rr.size() != 0) && cyc < 40) begin
         tick();
         cyc++;
      end
      chk({tag, "_fp_left"}, 32'(q_fp.size()), 32'd0);
      chk({tag, "_rr_left"}, 32'(q_rr.size()), 32'd0);
      chk({tag, "_cycles"},  32'(cyc),         32'(exp_cyc));
      chk({tag, "_fp_idle_pending"}, 32'(bus_fp.pending), 32'd0);
      chk({tag, "_rr_idle_pending"}, 32'(bus_rr.pending), 32'd0);
   endtask

   initial begin
      drive(4'b0000, 1'b0);

      // Reset values
      do_reset();
      both_state("rst", 1'b0, 2'd0, 4'b0000);
      both_ovf("rst", 1'b0);

      // Single event: pending after E0, presented after E1, gone after E2
      q_fp.push_back(2'd2);
      q_rr.push_back(2'd2);
      drive(4'b0100, 1'b1);
      tick();
      drive(4'b0000, 1'b1);
      both_state("single_e0", 1'b0, 2'd0, 4'b0100);
      tick();
      both_state("single_e1", 1'b1, 2'd2, 4'b0000);
      tick();
      chk("single_e2_fp_valid", 32'(bus_fp.valid), 32'd0);
      chk("single_e2_rr_valid", 32'(bus_rr.valid), 32'd0);
      chk("single_code_hold",   32'(bus_fp.code),  32'd2);

      // Burst 1011: fixed gives 3,1,0; round-robin from last=3 gives 0,1,3
      do_reset();
      q_fp.push_back(2'd3); q_fp.push_back(2'd1); q_fp.push_back(2'd0);
      q_rr.push_back(2'd0); q_rr.push_back(2'd1); q_rr.push_back(2'd3);
      drive(4'b1011, 1'b1);
      tick();
      drive(4'b0000, 1'b1);
      drain("burst", 4);

      // All four, then 1001 continuing from last=3
      do_reset();
      q_fp.push_back(2'd3); q_fp.push_back(2'd2); q_fp.push_back(2'd1); q_fp.push_back(2'd0);
      q_rr.push_back(2'd0); q_rr.push_back(2'd1); q_rr.push_back(2'd2); q_rr.push_back(2'd3);
      drive(4'b1111, 1'b1);
      tick();
      drive(4'b0000, 1'b1);
      drain("all4", 5);
      q_fp.push_back(2'd3); q_fp.push_back(2'd0);
      q_rr.push_back(2'd0); q_rr.push_back(2'd3);
      drive(4'b1001, 1'b1);
      tick();
      drive(4'b0000, 1'b1);
      drain("pair", 3);

      // Backpressure and overflow on index 1
      do_reset();
      drive(4'b0010, 1'b0);
      tick();
      drive(4'b0000, 1'b0);
      both_ovf("bp_first", 1'b0);
      tick();
      both_state("bp_presented", 1'b1, 2'd1, 4'b0000);
      drive(4'b0010, 1'b0);
      tick();
      drive(4'b0000, 1'b0);
      both_state("bp_second", 1'b1, 2'd1, 4'b0010);
      both_ovf("bp_second", 1'b0);
      tick();
      drive(4'b0010, 1'b0);
      tick();
      drive(4'b0000, 1'b0);
      both_ovf("bp_third", 1'b1);
      both_state("bp_third", 1'b1, 2'd1, 4'b0010);
      tick();
      both_ovf("bp_after", 1'b0);
      q_fp.push_back(2'd1); q_fp.push_back(2'd1);
      q_rr.push_back(2'd1); q_rr.push_back(2'd1);
      drive(4'b0000, 1'b1);
      drain("bp_release", 2);

      // Reset in the middle of a held handshake drops everything
      do_reset();
      drive(4'b0001, 1'b0);
      tick();
      drive(4'b1100, 1'b0);
      tick();
      drive(4'b0000, 1'b0);
      both_state("mid_before", 1'b1, 2'd0, 4'b1100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      both_state("mid_after", 1'b0, 2'd0, 4'b0000);
      drive(4'b0000, 1'b1);
      for (int i = 0; i < 6; i++) tick();
      both_state("mid_quiet", 1'b0, 2'd0, 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1);
   end

endmodule

// File: doc/event_encoder_4to2.md
# event_encoder_4to2

Sequential 4-to-2 encoder for the 2-to-4 decode path. It captures single-cycle events on four one-hot-style request lines into sticky pending bits. It then emits them one at a time as 2-bit indices over a valid/ready handshake, which can be fed back into the 2-to-4 decoder downstream. Simultaneous or back-to-back events are never lost silently: they are queued in the pending bits, or flagged on `overflow`.

## Interface
- `ROUND_ROBIN`, default 0: 0 selects fixed priority (index 3 highest, 0 lowest); 1 selects round-robin starting after the last index emitted.

- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  4  event pulses; `req[i]` high for any cycle = one event on index i
- `ready`  in  1  consumer accepts `code` when `valid && ready`
- `code`  out  2  encoded index of presented event
- `valid`  out  1  `code` holds an unconsumed event
- `pending`  out  4  registered sticky event bits awaiting emission
- `overflow`  out  1  one-cycle pulse: event merged into an already-pending bit

## Operation
- Reset: `pending`=0000, `code`=00, `valid`=0, `overflow`=0, RR pointer `last`=3. State=IDLE.
- State machine has two states:
  - IDLE (`valid`=0).
  - PRESENT (`valid`=1).
- Winner selection uses registered `pending` only. A `req` never bypasses into `code` in the same cycle.
  - Fixed mode: highest set index.
  - RR mode: first set index searching `last+1, last+2, …` modulo 4.
- Load event (`load`) occurs in either of two cases:
  - State IDLE with `pending`≠0.
  - State PRESENT with `valid && ready` and `pending`≠0.
- On `load`:
  - `code`←winner, `valid`←1, `last`←winner.
  - `pending[winner]` is cleared, unless `req[winner]` is high the same cycle; then it stays set as a new event.
- PRESENT with `valid && ready` and `pending`=0: `valid`←0, go IDLE. `code` holds its last value.
- PRESENT with `ready`=0: `code`/`valid` hold stable; no reselection even if higher-priority bits arrive.
- Pending update per bit: `pending[i]` ← (`pending[i]` & ~clear_i) | `req[i]`.
- `overflow` ← 1 for one cycle iff, for some i, `req[i]`=1, `pending[i]`=1 and clear_i=0. The events are merged, so the count of lost events is one per flagged bit.
- A `req` on the index currently presented in `code` is a new event. It sets `pending` and is not an overflow.
- `rst` high in any state, including mid-handshake, returns all registers to their reset values at that edge. The unconsumed event and all pending bits are dropped.

## Timing
- Event latency: `req[i]` high at edge E0 → `pending[i]`=1 after E0 → `valid`=1 with `code`=i after E1, when idle and it is the winner.
- Throughput: one event per cycle with `ready` held high. Handshakes are back-to-back with no idle bubble while `pending`≠0.
- `overflow` is asserted for the cycle after the colliding edge, then deasserts unless it collides again.
- All outputs are registered; no combinational path from `req` or `ready` to any output.

## Test plan
- Reset check: hold `rst` 2 cycles → `pending`=0000, `valid`=0, `code`=00, `overflow`=0.
- Single event: `req`=0100 for 1 cycle, `ready`=1 → 2 edges later `valid`=1, `code`=10 for exactly 1 cycle; `pending` returns to 0000.
- Fixed priority burst: `ROUND_ROBIN`=0, `req`=1011 for 1 cycle, `ready`=1 → codes 11, 01, 00 on consecutive cycles, then `valid`=0.
- Round-robin: `ROUND_ROBIN`=1, after reset `req`=1111 once → codes 00, 01, 10, 11. Then `req`=1001 once → 00, 11.
- Backpressure and overflow: `ready`=0, `req`=0010 on two separate cycles → `code`=01 held. Second `req` while pending → sets `pending[1]` (not overflow). A third `req`=0010 → `overflow`=1 for one cycle. Raise `ready` → exactly two `code`=01 handshakes.
- Mid-operation reset: `valid`=1, `pending`=1100, assert `rst` one cycle → next cycle `valid`=0, `pending`=0000, no further handshakes.
